int_ctrl: RTL and testbench

Hardware interrupt controller that merges up to `N_SRC` peripheral interrupt lines into the single `hwint` request consumed by the control unit. It latches rising edges as pending bits and masks them with a software-written enable register. It runs a request/acknowledge/end-of-interrupt handshake with the CPU and exposes a priority vector so the handler at address 0x00000001 can identify the source. It sits on the memory-mapped register bus beside the CPU.

---
 rtl/int_ctrl.sv | 144 ++++++++++++++
 tb/tb_int_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl
// Description : Hardware interrupt controller. Latches rising edges of up to
//               N_SRC peripheral lines as pending bits, masks them with a
//               software enable register, and runs a request / acknowledge /
//               end-of-interrupt handshake with the CPU through hwint. A
//               vector register identifies the source being serviced.
// Revision    : 1.0 - initial release
// ============================================================================
module int_ctrl #(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq,
    input  logic             int_ack,
    input  logic             reg_rd,
    input  logic             reg_wr,
    input  logic [1:0]       reg_addr,
    input  logic [31:0]      reg_wdata,
    output logic [31:0]      reg_rdata,
    output logic             hwint
);

    // Register map
    localparam logic [1:0] c_ADDR_PENDING = 2'd0;
    localparam logic [1:0] c_ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] c_ADDR_VECTOR  = 2'd2;
    localparam logic [1:0] c_ADDR_EOI     = 2'd3;

    // Handshake states
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_REQ     = 2'd1;
    localparam logic [1:0] c_ST_SERVICE = 2'd2;

    logic [N_SRC-1:0] r_irq_q;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_enable;
    logic [1:0]       r_state;
    logic [4:0]       r_in_service;

    logic [N_SRC-1:0] w_edge;
    logic [N_SRC-1:0] w_eligible;
    logic [N_SRC-1:0] w_lowest;
    logic [N_SRC-1:0] w_w1c;
    logic [N_SRC-1:0] w_ack_clr;
    logic [4:0]       w_winner;
    logic             w_ack_take;
    logic             w_eoi;
    logic [31:0]      w_pending_ext;
    logic [31:0]      w_enable_ext;

    assign w_edge     = irq & ~r_irq_q;
    assign w_eligible = r_pending & r_enable;
    // Isolate the lowest set bit: bit 0 has the highest priority.
    assign w_lowest   = w_eligible & (-w_eligible);
    assign w_ack_take = (r_state == c_ST_REQ) && int_ack;
    assign w_ack_clr  = w_ack_take ? w_lowest : '0;
    assign w_w1c      = (reg_wr && (reg_addr == c_ADDR_PENDING)) ? reg_wdata[N_SRC-1:0] : '0;
    assign w_eoi      = reg_wr && (reg_addr == c_ADDR_EOI);
    assign hwint      = (r_state == c_ST_REQ);

    // Write data bits above the implemented sources are intentionally ignored.
    if (N_SRC < 32) begin : g_unused_wdata
        logic w_unused_wdata;
        assign w_unused_wdata = ^reg_wdata[31:N_SRC];
    end

    // Index of the lowest eligible source (0 when none is eligible).
    always_comb begin
        w_winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = 5'(i);
            end
        end
    end

    // Zero-extend the source-wide registers to the 32-bit bus.
    always_comb begin
        w_pending_ext              = '0;
        w_enable_ext               = '0;
        w_pending_ext[N_SRC-1:0]   = r_pending;
        w_enable_ext[N_SRC-1:0]    = r_enable;
    end

    // Combinational register read; the bus sees 0 when not reading.
    always_comb begin
        reg_rdata = '0;
        if (reg_rd) begin
            case (reg_addr)
                c_ADDR_PENDING: reg_rdata = w_pending_ext;
                c_ADDR_ENABLE:  reg_rdata = w_enable_ext;
                c_ADDR_VECTOR:  reg_rdata = {(r_state == c_ST_SERVICE), 26'd0, r_in_service};
                default:        reg_rdata = '0;
            endcase
        end
    end

    // Edge capture, pending/enable registers and the handshake state machine.
    // New edges are OR-ed in last so a same-cycle set beats any clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_q      <= '0;
            r_pending    <= '0;
            r_enable     <= '0;
            r_state      <= c_ST_IDLE;
            r_in_service <= '0;
        end else begin
            r_irq_q   <= irq;
            r_pending <= (r_pending & ~(w_w1c | w_ack_clr)) | w_edge;
            if (reg_wr && (reg_addr == c_ADDR_ENABLE)) begin
                r_enable <= reg_wdata[N_SRC-1:0];
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (|w_eligible) begin
                        r_state <= c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    if (w_ack_take) begin
                        r_in_service <= w_winner;
                        r_state      <= c_ST_SERVICE;
                    end else if (!(|w_eligible)) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_SERVICE: begin
                    if (w_eoi) begin
                        r_in_service <= '0;
                        r_state      <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_ctrl
// Description : Directed self-checking bench for int_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  irq;
    logic        int_ack;
    logic        reg_rd;
    logic        reg_wr;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        hwint;

    int n_cmp;
    int n_err;

    int_ctrl #(.N_SRC(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq),
        .int_ack   (int_ack),
        .reg_rd    (reg_rd),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .hwint     (hwint)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        reg_rd   = 1'b1;
        reg_addr = a;
        #1;
        d        = reg_rdata;
        reg_rd   = 1'b0;
        chk(tag, d, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        reg_wr    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        tick();
        reg_wr    = 1'b0;
        reg_wdata = '0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        irq       = '0;
        int_ack   = 1'b0;
        reg_rd    = 1'b0;
        reg_wr    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_hwint", {31'd0, hwint}, 32'd0);
        chk_rd("rst_pending", 2'd0, 32'd0);
        chk_rd("rst_enable", 2'd1, 32'd0);
        chk_rd("rst_vector", 2'd2, 32'd0);
        chk_rd("rst_eoi", 2'd3, 32'd0);

        // Basic flow on source 2
        wr(2'd1, 32'h04);
        irq = 8'h04;
        tick();
        irq = 8'h00;
        chk("basic_hwint_t", {31'd0, hwint}, 32'd0);
        tick();
        chk("basic_hwint_t1", {31'd0, hwint}, 32'd1);
        reg_rd   = 1'b0;
        reg_addr = 2'd1;
        #1;
        chk("rdata_no_rd", reg_rdata, 32'd0);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("basic_hwint_ack", {31'd0, hwint}, 32'd0);
        chk_rd("basic_vector", 2'd2, 32'h8000_0002);
        chk_rd("basic_pending", 2'd0, 32'd0);
        wr(2'd3, 32'h0);
        chk_rd("basic_vec_eoi", 2'd2, 32'd0);

        // Priority: sources 5 and 3 together
        wr(2'd1, 32'hFF);
        irq = 8'h28;
        tick();
        irq = 8'h00;
        tick();
        chk("prio_hwint", {31'd0, hwint}, 32'd1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk_rd("prio_vec3", 2'd2, 32'h8000_0003);
        chk_rd("prio_pend", 2'd0, 32'h20);
        wr(2'd3, 32'h0);
        chk("prio_gap", {31'd0, hwint}, 32'd0);
        tick();
        chk("prio_rereq", {31'd0, hwint}, 32'd1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk_rd("prio_vec5", 2'd2, 32'h8000_0005);
        chk_rd("prio_pend0", 2'd0, 32'd0);
        wr(2'd3, 32'h0);

        // Masking and withdrawal
        wr(2'd1, 32'h0);
        irq = 8'h02;
        tick();
        irq = 8'h00;
        tick();
        chk_rd("mask_pend", 2'd0, 32'h02);
        chk("mask_hwint", {31'd0, hwint}, 32'd0);
        wr(2'd1, 32'h02);
        tick();
        chk("mask_en_hwint", {31'd0, hwint}, 32'd1);
        wr(2'd0, 32'h02);
        chk_rd("w1c_pend", 2'd0, 32'd0);
        tick();
        chk("w1c_hwint", {31'd0, hwint}, 32'd0);
        chk_rd("w1c_vector", 2'd2, 32'd0);

        // Level-held line sets pending only once
        wr(2'd1, 32'h01);
        irq = 8'h01;
        for (int i = 0; i < 10; i++) tick();
        chk("level_hwint", {31'd0, hwint}, 32'd1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk_rd("level_vec", 2'd2, 32'h8000_0000);
        wr(2'd3, 32'h0);
        tick();
        tick();
        chk("level_no_rereq", {31'd0, hwint}, 32'd0);
        chk_rd("level_pend", 2'd0, 32'd0);
        irq = 8'h00;
        tick();

        // Collisions: ack + W1C of winner, edges + W1C of the same bit,
        // and a new higher-priority edge in the ack cycle
        wr(2'd1, 32'hFF);
        irq = 8'h10;
        tick();
        irq = 8'h00;
        tick();
        chk("coll_hwint", {31'd0, hwint}, 32'd1);
        int_ack   = 1'b1;
        irq       = 8'h42;
        reg_wr    = 1'b1;
        reg_addr  = 2'd0;
        reg_wdata = 32'h50;
        tick();
        int_ack   = 1'b0;
        irq       = 8'h00;
        reg_wr    = 1'b0;
        reg_wdata = '0;
        chk_rd("coll_vec", 2'd2, 32'h8000_0004);
        chk_rd("coll_pend", 2'd0, 32'h42);
        // Ack while in service is ignored
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk_rd("svc_ack_vec", 2'd2, 32'h8000_0004);
        chk_rd("svc_ack_pend", 2'd0, 32'h42);
        wr(2'd0, 32'hFF);
        wr(2'd3, 32'h0);
        // Spurious ack in IDLE
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("idle_ack_hwint", {31'd0, hwint}, 32'd0);
        chk_rd("idle_ack_vec", 2'd2, 32'd0);

        // EOI in REQ ignored; ENABLE write in the ack cycle uses the old ENABLE
        wr(2'd1, 32'h0C);
        irq = 8'h0C;
        tick();
        irq = 8'h00;
        tick();
        wr(2'd3, 32'h0);
        chk("req_eoi_hwint", {31'd0, hwint}, 32'd1);
        int_ack   = 1'b1;
        reg_wr    = 1'b1;
        reg_addr  = 2'd1;
        reg_wdata = 32'h08;
        tick();
        int_ack   = 1'b0;
        reg_wr    = 1'b0;
        reg_wdata = '0;
        chk_rd("en_ack_vec", 2'd2, 32'h8000_0002);
        chk_rd("en_ack_pend", 2'd0, 32'h08);
        chk_rd("en_ack_en", 2'd1, 32'h08);

        // Asynchronous reset while in SERVICE
        rst = 1'b1;
        #1;
        chk("arst_hwint", {31'd0, hwint}, 32'd0);
        chk_rd("arst_vec", 2'd2, 32'd0);
        chk_rd("arst_pend", 2'd0, 32'd0);
        chk_rd("arst_en", 2'd1, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_hwint", {31'd0, hwint}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
